// File: rtl/uart_tx_drain.sv
// ----------------------------------------------------------------------------
// uart_tx_drain
//
// UART transmitter sitting on the read side of a first-word-fall-through TX
// FIFO. Whenever the FIFO holds data and the block is enabled, it pops one
// byte and serializes it as start bit, DATA_WIDTH data bits (LSB first),
// an optional even-parity bit and STOP_BITS stop bits. Frames run
// back-to-back with no idle gap while data remains.
//
// Optional feature macro:
//   UART_TX_PARITY_EN - when defined, an even-parity bit (XOR of the data
//                       bits) is sent between the last data bit and stop.
//
// Parameters:
//   CLKS_PER_BAUD - clock cycles per bit period (>= 2)
//   DATA_WIDTH    - bits per character (matches FIFO width)
//   STOP_BITS     - 1 or 2
//
// Ports:
//   i_clk          - system clock, rising edge
//   i_reset_w      - synchronous active-high reset
//   i_enable_w     - permits starting new frames; frame in flight completes
//   i_fifo_data_w  - FIFO head data (valid while not empty)
//   i_fifo_empty_w - FIFO empty flag
//   o_fifo_read_w  - single-cycle pop strobe to the FIFO
//   o_tx_w         - serial line, idles high (registered)
//   o_busy_w       - high while a frame is on the line (registered)
// ----------------------------------------------------------------------------
module uart_tx_drain #(
    parameter int CLKS_PER_BAUD = 868,
    parameter int DATA_WIDTH    = 8,
    parameter int STOP_BITS     = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_w,
    input  logic                  i_enable_w,
    input  logic [DATA_WIDTH-1:0] i_fifo_data_w,
    input  logic                  i_fifo_empty_w,
    output logic                  o_fifo_read_w,
    output logic                  o_tx_w,
    output logic                  o_busy_w
);

    localparam int CW = $clog2(CLKS_PER_BAUD);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BAUD - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST   = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         baud_cnt, baud_cnt_n;
    logic [BW-1:0]         bit_idx, bit_idx_n;
    logic                  stop_cnt, stop_cnt_n;
    logic [DATA_WIDTH-1:0] shift, shift_n;
    logic                  tx_n;
    logic                  busy_n;
    logic                  bit_end;
    logic                  frame_end;
    logic                  pop;
`ifdef UART_TX_PARITY_EN
    logic                  parity, parity_n;
`endif

    assign bit_end   = (baud_cnt == '0);
    assign frame_end = (state == S_STOP) && bit_end && (stop_cnt == STOP_LAST);

    // Reset is folded in so a pop can never coincide with reset.
    assign pop = ((state == S_IDLE) || frame_end) &&
                 !i_fifo_empty_w && i_enable_w && !i_reset_w;

    assign o_fifo_read_w = pop;

    always_ff @(posedge i_clk) begin
        if (i_reset_w) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            shift    <= '0;
            o_tx_w   <= 1'b1;
            o_busy_w <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            stop_cnt <= stop_cnt_n;
            shift    <= shift_n;
            o_tx_w   <= tx_n;
            o_busy_w <= busy_n;
`ifdef UART_TX_PARITY_EN
            parity   <= parity_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        baud_cnt_n = bit_end ? baud_cnt : baud_cnt - CW'(1);
        bit_idx_n  = bit_idx;
        stop_cnt_n = stop_cnt;
        shift_n    = shift;
`ifdef UART_TX_PARITY_EN
        parity_n   = parity;
`endif

        case (state)
            S_IDLE: begin
                baud_cnt_n = baud_cnt;
                if (pop) begin
                    state_n    = S_START;
                    baud_cnt_n = BAUD_RELOAD;
                    shift_n    = i_fifo_data_w;
`ifdef UART_TX_PARITY_EN
                    parity_n   = ^i_fifo_data_w;
`endif
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_n    = S_DATA;
                    baud_cnt_n = BAUD_RELOAD;
                    bit_idx_n  = '0;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_cnt_n = BAUD_RELOAD;
                    shift_n    = shift >> 1;
                    if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_n    = S_PARITY;
`else
                        state_n    = S_STOP;
                        stop_cnt_n = 1'b0;
`endif
                    end else begin
                        bit_idx_n = bit_idx + BW'(1);
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_n    = S_STOP;
                    baud_cnt_n = BAUD_RELOAD;
                    stop_cnt_n = 1'b0;
                end
            end
`endif

            S_STOP: begin
                if (bit_end) begin
                    if (stop_cnt == STOP_LAST) begin
                        // Next frame's start bit follows the last stop bit directly.
                        if (pop) begin
                            state_n    = S_START;
                            baud_cnt_n = BAUD_RELOAD;
                            shift_n    = i_fifo_data_w;
`ifdef UART_TX_PARITY_EN
                            parity_n   = ^i_fifo_data_w;
`endif
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        baud_cnt_n = BAUD_RELOAD;
                        stop_cnt_n = 1'b1;
                    end
                end
            end

            default: begin
                state_n    = S_IDLE;
                baud_cnt_n = '0;
            end
        endcase

        // Line and busy are registered from the next state so the line
        // changes on the same edge that the state does.
        tx_n   = 1'b1;
        busy_n = (state_n != S_IDLE);
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_n = parity_n;
`endif
            default:  tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_drain
//
// Directed bench for uart_tx_drain with CLKS_PER_BAUD=4, STOP_BITS=1.
// A small array-based FWFT FIFO feeds the DUT. Inputs change on the falling
// edge; outputs are sampled 1 time unit after the falling edge.
// Defining UART_TX_PARITY_EN adds the parity frame scenario.
// ----------------------------------------------------------------------------
module tb_uart_tx_drain;

    localparam int BAUD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BAUD;

    logic       clk = 1'b0;
    logic       reset_w;
    logic       enable_w;
    logic [7:0] fifo_data_w;
    logic       fifo_empty_w;
    logic       fifo_read_w;
    logic       tx_w;
    logic       busy_w;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [0:15];
    int wr = 0;
    int rd = 0;
    int pop_count = 0;
    int bad_pops  = 0;

    always #5 clk = ~clk;

    assign fifo_empty_w = (wr == rd);
    assign fifo_data_w  = mem[rd % 16];

    always @(posedge clk) begin
        if (fifo_read_w) begin
            if (wr == rd) bad_pops++;
            else rd++;
            pop_count++;
        end
    end

    uart_tx_drain #(
        .CLKS_PER_BAUD(BAUD),
        .DATA_WIDTH   (8),
        .STOP_BITS    (1)
    ) dut (
        .i_clk         (clk),
        .i_reset_w     (reset_w),
        .i_enable_w    (enable_w),
        .i_fifo_data_w (fifo_data_w),
        .i_fifo_empty_w(fifo_empty_w),
        .o_fifo_read_w (fifo_read_w),
        .o_tx_w        (tx_w),
        .o_busy_w      (busy_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr % 16] = b;
        wr++;
    endtask

    // Advance to the next sample point (falling edge + 1).
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Waits for the pop strobe; returns positioned in the pop cycle (cycle 0).
    task automatic wait_pop(input int limit, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (fifo_read_w === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    // Checks cycles 1..FRAME after a pop: line pattern, busy, and whether the
    // next pop is expected in the final stop-bit cycle.
    task automatic check_frame(input logic [7:0] b, input bit next, input string tag);
        int idx;
        logic exp_tx;
        for (int k = 1; k <= FRAME; k++) begin
            step();
            idx = (k - 1) / BAUD;
            if (idx == 0)                  exp_tx = 1'b0;
            else if (idx <= 8)             exp_tx = b[idx-1];
`ifdef UART_TX_PARITY_EN
            else if (idx == 9)             exp_tx = ^b;
`endif
            else                           exp_tx = 1'b1;
            chk({tag, "_tx"},   {31'd0, tx_w},   {31'd0, exp_tx});
            chk({tag, "_busy"}, {31'd0, busy_w}, 32'd1);
            chk({tag, "_read"}, {31'd0, fifo_read_w}, {31'd0, (k == FRAME) && next});
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_tx"},   {31'd0, tx_w},   32'd1);
        chk({tag, "_busy"}, {31'd0, busy_w}, 32'd0);
        chk({tag, "_read"}, {31'd0, fifo_read_w}, 32'd0);
    endtask

    initial begin
        int pops_before;

        // 1. Reset with FIFO non-empty and enabled: no pop during reset.
        reset_w  = 1'b1;
        enable_w = 1'b1;
        push(8'hA5);
        #1;
        chk("rst_read0", {31'd0, fifo_read_w}, 32'd0);
        step();
        check_idle("rst_c1");
        step();
        check_idle("rst_c2");

        // 2. Single byte 0xA5 after reset release.
        reset_w = 1'b0;
        #1;
        pops_before = pop_count;
        wait_pop(3, "a5_pop");
        check_frame(8'hA5, 1'b0, "a5");
        step();
        check_idle("a5_after");
        chk("a5_popcnt", pop_count - pops_before, 1);

        // 3. Back-to-back 0x00 then 0xFF.
        push(8'h00);
        push(8'hFF);
        #1;
        pops_before = pop_count;
        wait_pop(3, "b2b_pop");
        check_frame(8'h00, 1'b1, "b2b0");
        check_frame(8'hFF, 1'b0, "b2b1");
        step();
        check_idle("b2b_after");
        chk("b2b_popcnt", pop_count - pops_before, 2);

        // 4a. Empty FIFO with enable: nothing happens.
        for (int i = 0; i < 50; i++) begin
            step();
            check_idle("empty");
        end

        // 4b. Disabled with 0x3C queued: 100 cycles of idle.
        enable_w = 1'b0;
        push(8'h3C);
        for (int i = 0; i < 100; i++) begin
            step();
            check_idle("disabled");
        end
        enable_w = 1'b1;
        #1;
        wait_pop(2, "en_pop");
        check_frame(8'h3C, 1'b0, "x3c");
        step();
        check_idle("x3c_after");

        // 5. Reset during data bit 3 of 0x55.
        push(8'h55);
        #1;
        pops_before = pop_count;
        wait_pop(3, "r55_pop");
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k >= 17) chk("r55_bit3", {31'd0, tx_w}, 32'd0);
        end
        reset_w = 1'b1;
        step();
        check_idle("r55_abort");
        reset_w = 1'b0;
        step();
        check_idle("r55_noreread");
        chk("r55_popcnt", pop_count - pops_before, 1);
        push(8'h81);
        #1;
        wait_pop(3, "x81_pop");
        check_frame(8'h81, 1'b0, "x81");
        step();
        check_idle("x81_after");

`ifdef UART_TX_PARITY_EN
        // 6. Parity frames: 0x07 (parity 1) and 0x03 (parity 0).
        push(8'h07);
        push(8'h03);
        #1;
        wait_pop(3, "par_pop");
        check_frame(8'h07, 1'b1, "par07");
        check_frame(8'h03, 1'b0, "par03");
        step();
        check_idle("par_after");
`endif

        chk("no_empty_pops", bad_pops, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
